// File: rtl/mirfak_lsu_stage.sv
// mirfak_lsu_stage: write-back stage load/store unit.
// Takes one load or store from the pipeline, checks alignment and access
// format, and runs a single Wishbone-style classic cycle on the data bus.
// It reports completion, load data, misalignment and access faults.
//
// Handshake: a request is accepted only in IDLE, in the cycle it is presented
// (lsu_busy_o rises combinationally). Once cyc/stb are raised, every bus output
// is held until the first edge that samples ack or err (ack has priority).
// The pipeline sees exactly one DONE cycle after that edge.
module mirfak_lsu_stage #(
    parameter int unsigned BUS_TIMEOUT      = 0,
    parameter bit          ENABLE_FMT_CHECK = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wb_alu_result_i,
    input  logic [31:0] wb_lsu_wdata_i,
    input  logic [2:0]  wb_funct3_i,
    input  logic        wb_mem_read_i,
    input  logic        wb_mem_write_i,
    input  logic        wb_bubble_i,
    input  logic        wb_exception_i,
    input  logic        wb_kill_i,
    output logic [31:0] dwbm_addr_o,
    output logic [31:0] dwbm_dat_o,
    output logic [3:0]  dwbm_sel_o,
    output logic        dwbm_cyc_o,
    output logic        dwbm_stb_o,
    output logic        dwbm_we_o,
    input  logic [31:0] dwbm_dat_i,
    input  logic        dwbm_ack_i,
    input  logic        dwbm_err_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_done_o,
    output logic        lsu_busy_o,
    output logic        lsu_ld_misaligned_o,
    output logic        lsu_st_misaligned_o,
    output logic        lsu_ld_fault_o,
    output logic        lsu_st_fault_o,
    output logic [31:0] lsu_mtval_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic        r_cyc;
    logic        r_we;
    logic        r_acc_wr;   // access direction, kept after we drops
    logic [31:0] r_addr;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    logic [31:0] r_rdata;
    logic [31:0] r_mtval;    // byte address of the access in flight
    logic [2:0]  r_f3;
    logic        r_fault;
    logic        r_killed;
    logic [31:0] r_cnt;

    logic        w_req;
    logic        w_idle_req;
    logic        w_fmt_bad;
    logic        w_misaligned;
    logic        w_issue;
    logic        w_timeout;
    logic        w_report;
    logic [1:0]  w_size;
    logic [3:0]  w_sel;
    logic [31:0] w_st_dat;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    // Reset is folded in so no flag or busy can show while rst_ni is low.
    assign w_req = rst_ni & (wb_mem_read_i | wb_mem_write_i) & ~wb_bubble_i
                   & ~wb_exception_i & ~wb_kill_i;
    assign w_idle_req = w_req & (r_state == S_IDLE);

    assign w_fmt_bad = ENABLE_FMT_CHECK && ((wb_funct3_i == 3'b011) ||
                       (wb_funct3_i == 3'b110) || (wb_funct3_i == 3'b111));
    // Unflagged 011/110/111 fall back to a full word access.
    assign w_size = (wb_funct3_i[1:0] == 2'b11) ? 2'b10 : wb_funct3_i[1:0];
    assign w_misaligned = ~w_fmt_bad &
                          (((w_size == 2'b01) & wb_alu_result_i[0]) |
                           ((w_size == 2'b10) & (wb_alu_result_i[1:0] != 2'b00)));
    assign w_issue = w_idle_req & ~w_fmt_bad & ~w_misaligned;

    assign w_timeout = (BUS_TIMEOUT != 0) && (r_cnt == BUS_TIMEOUT - 1);
    assign w_report  = (r_state == S_DONE) & ~r_killed;

    // Byte lanes and write data replication for the requested store size.
    always_comb begin
        w_sel    = 4'b1111;
        w_st_dat = wb_lsu_wdata_i;
        case (w_size)
            2'b00: begin
                w_sel    = 4'b0001 << wb_alu_result_i[1:0];
                w_st_dat = {4{wb_lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                w_sel    = wb_alu_result_i[1] ? 4'b1100 : 4'b0011;
                w_st_dat = {2{wb_lsu_wdata_i[15:0]}};
            end
            default: begin
                w_sel    = 4'b1111;
                w_st_dat = wb_lsu_wdata_i;
            end
        endcase
    end

    // Pick the addressed lane out of the returned bus word and extend it.
    always_comb begin
        w_byte    = 8'h00;
        w_half    = r_mtval[1] ? dwbm_dat_i[31:16] : dwbm_dat_i[15:0];
        w_ld_data = dwbm_dat_i;
        case (r_mtval[1:0])
            2'b00:   w_byte = dwbm_dat_i[7:0];
            2'b01:   w_byte = dwbm_dat_i[15:8];
            2'b10:   w_byte = dwbm_dat_i[23:16];
            default: w_byte = dwbm_dat_i[31:24];
        endcase
        case (r_f3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'h000000, w_byte};
            3'b101:  w_ld_data = {16'h0000, w_half};
            default: w_ld_data = dwbm_dat_i;
        endcase
    end

    // Access FSM: capture the bus cycle in IDLE, wait for ack/err/timeout, report once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_acc_wr <= 1'b0;
            r_addr   <= 32'h0;
            r_sel    <= 4'h0;
            r_dat    <= 32'h0;
            r_rdata  <= 32'h0;
            r_mtval  <= 32'h0;
            r_f3     <= 3'b000;
            r_fault  <= 1'b0;
            r_killed <= 1'b0;
            r_cnt    <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state  <= S_BUSY;
                        r_cyc    <= 1'b1;
                        r_we     <= wb_mem_write_i;
                        r_acc_wr <= wb_mem_write_i;
                        r_addr   <= {wb_alu_result_i[31:2], 2'b00};
                        r_sel    <= w_sel;
                        r_dat    <= wb_mem_write_i ? w_st_dat : 32'h0;
                        r_mtval  <= wb_alu_result_i;
                        r_f3     <= wb_funct3_i;
                        r_fault  <= 1'b0;
                        r_killed <= 1'b0;
                        r_cnt    <= 32'h0;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 32'd1;
                    // The bus cycle still finishes; only the report is dropped.
                    if (wb_kill_i) begin
                        r_killed <= 1'b1;
                    end
                    if (dwbm_ack_i | dwbm_err_i | w_timeout) begin
                        r_state <= S_DONE;
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        if (dwbm_ack_i) begin
                            if (!r_acc_wr) begin
                                r_rdata <= w_ld_data;
                            end
                        end else begin
                            r_fault <= 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dwbm_addr_o = r_addr;
    assign dwbm_dat_o  = r_dat;
    assign dwbm_sel_o  = r_sel;
    assign dwbm_cyc_o  = r_cyc;
    assign dwbm_stb_o  = r_cyc;
    assign dwbm_we_o   = r_we;

    assign lsu_rdata_o = r_rdata;
    assign lsu_busy_o  = (r_state == S_BUSY) | w_issue;
    assign lsu_done_o  = w_report & ~r_fault;

    assign lsu_ld_misaligned_o = w_idle_req & ~wb_mem_write_i & w_misaligned;
    assign lsu_st_misaligned_o = w_idle_req &  wb_mem_write_i & w_misaligned;
    assign lsu_ld_fault_o = (w_idle_req & ~wb_mem_write_i & w_fmt_bad) |
                            (w_report & r_fault & ~r_acc_wr);
    assign lsu_st_fault_o = (w_idle_req &  wb_mem_write_i & w_fmt_bad) |
                            (w_report & r_fault &  r_acc_wr);
    assign lsu_mtval_o = (w_idle_req & (w_fmt_bad | w_misaligned)) ?
                         wb_alu_result_i : r_mtval;

endmodule

// File: tb/tb_mirfak_lsu_stage.sv
// Bench for mirfak_lsu_stage: table of single accesses with a small bus
// responder, plus hand sequences for kill-in-flight and reset-in-flight.
module tb_mirfak_lsu_stage;

    localparam int unsigned TMO = 4;
    localparam logic [1:0] R_ACK  = 2'd0;
    localparam logic [1:0] R_ERR  = 2'd1;
    localparam logic [1:0] R_NONE = 2'd2;
    localparam logic [1:0] R_BOTH = 2'd3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] wb_alu_result_i, wb_lsu_wdata_i;
    logic [2:0]  wb_funct3_i;
    logic        wb_mem_read_i, wb_mem_write_i;
    logic        wb_bubble_i, wb_exception_i, wb_kill_i;
    logic [31:0] dwbm_addr_o, dwbm_dat_o, dwbm_dat_i;
    logic [3:0]  dwbm_sel_o;
    logic        dwbm_cyc_o, dwbm_stb_o, dwbm_we_o, dwbm_ack_i, dwbm_err_i;
    logic [31:0] lsu_rdata_o, lsu_mtval_o;
    logic        lsu_done_o, lsu_busy_o;
    logic        lsu_ld_misaligned_o, lsu_st_misaligned_o, lsu_ld_fault_o, lsu_st_fault_o;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  flag_q[$];
    logic [31:0] model_rdata = 32'h0;

    // {rd, wr, funct3, addr, wdata, bus data, response, delay (0=random),
    //  gates {bubble,exc,kill}, immediate, flags {done,ldm,stm,ldf,stf},
    //  result (rdata or mtval), store sel, store dat}
    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_dat;
        logic [1:0]  resp;
        int          dly;
        logic [2:0]  gate;
        bit          imm;
        logic [4:0]  flags;
        logic [31:0] res;
        logic [3:0]  sel;
        logic [31:0] dat;
    } vec_t;

    localparam int NV = 20;
    vec_t vt[NV];

    mirfak_lsu_stage #(.BUS_TIMEOUT(TMO), .ENABLE_FMT_CHECK(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wb_alu_result_i(wb_alu_result_i), .wb_lsu_wdata_i(wb_lsu_wdata_i),
        .wb_funct3_i(wb_funct3_i), .wb_mem_read_i(wb_mem_read_i),
        .wb_mem_write_i(wb_mem_write_i), .wb_bubble_i(wb_bubble_i),
        .wb_exception_i(wb_exception_i), .wb_kill_i(wb_kill_i),
        .dwbm_addr_o(dwbm_addr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
        .dwbm_cyc_o(dwbm_cyc_o), .dwbm_stb_o(dwbm_stb_o), .dwbm_we_o(dwbm_we_o),
        .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i),
        .lsu_rdata_o(lsu_rdata_o), .lsu_done_o(lsu_done_o), .lsu_busy_o(lsu_busy_o),
        .lsu_ld_misaligned_o(lsu_ld_misaligned_o), .lsu_st_misaligned_o(lsu_st_misaligned_o),
        .lsu_ld_fault_o(lsu_ld_fault_o), .lsu_st_fault_o(lsu_st_fault_o),
        .lsu_mtval_o(lsu_mtval_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    function automatic logic [4:0] flags_act();
        return {lsu_done_o, lsu_ld_misaligned_o, lsu_st_misaligned_o,
                lsu_ld_fault_o, lsu_st_fault_o};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_mem_read_i  = 1'b0;
        wb_mem_write_i = 1'b0;
        wb_bubble_i    = 1'b0;
        wb_exception_i = 1'b0;
        wb_kill_i      = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        wb_mem_read_i   = rd;
        wb_mem_write_i  = wr;
        wb_funct3_i     = f3;
        wb_alu_result_i = addr;
        wb_lsu_wdata_i  = wdata;
    endtask

    // One table access: drive, respond on the bus, compare the reported outcome.
    task automatic run_vec(input vec_t v, input int idx);
        int dly;
        int busy_cnt;
        int k;
        bit got;
        logic [31:0] e_res;
        logic [4:0]  e_fl;
        logic [31:0] e_busy;
        dly = (v.dly == 0) ? int'($urandom_range(1, 3)) : v.dly;
        @(negedge clk_i);
        drive(v.rd, v.wr, v.f3, v.addr, v.wdata);
        {wb_bubble_i, wb_exception_i, wb_kill_i} = v.gate;
        exp_q.push_back(v.res);
        flag_q.push_back(v.flags);
        #1;
        if (v.imm) begin
            e_res = exp_q.pop_front();
            e_fl  = flag_q.pop_front();
            check($sformatf("v%0d_flags", idx), {27'h0, flags_act()}, {27'h0, e_fl});
            if (e_fl != 5'b0) check($sformatf("v%0d_mtval", idx), lsu_mtval_o, e_res);
            check($sformatf("v%0d_busy", idx), {31'h0, lsu_busy_o}, 32'h0);
            @(posedge clk_i); #1;
            idle_inputs();
            check($sformatf("v%0d_nocyc", idx), {31'h0, dwbm_cyc_o}, 32'h0);
        end else begin
            check($sformatf("v%0d_busy_issue", idx), {31'h0, lsu_busy_o}, 32'h1);
            @(posedge clk_i); #1;
            idle_inputs();
            check($sformatf("v%0d_cyc", idx), {30'h0, dwbm_cyc_o, dwbm_stb_o}, 32'h3);
            check($sformatf("v%0d_we", idx), {31'h0, dwbm_we_o}, {31'h0, v.wr});
            check($sformatf("v%0d_addr", idx), dwbm_addr_o, {v.addr[31:2], 2'b00});
            if (v.wr) begin
                check($sformatf("v%0d_sel", idx), {28'h0, dwbm_sel_o}, {28'h0, v.sel});
                check($sformatf("v%0d_dat", idx), dwbm_dat_o, v.dat);
            end
            busy_cnt = 1;
            k = 0;
            got = 1'b0;
            while (!got && k < 20) begin
                if (flags_act() != 5'b0) begin
                    got = 1'b1;
                end else begin
                    if (lsu_busy_o) busy_cnt++;
                    k++;
                    if (v.resp != R_NONE && k == dly) begin
                        dwbm_dat_i = v.bus_dat;
                        dwbm_ack_i = (v.resp == R_ACK) || (v.resp == R_BOTH);
                        dwbm_err_i = (v.resp == R_ERR) || (v.resp == R_BOTH);
                    end
                    @(posedge clk_i); #1;
                    dwbm_ack_i = 1'b0;
                    dwbm_err_i = 1'b0;
                end
            end
            e_res = exp_q.pop_front();
            e_fl  = flag_q.pop_front();
            if (!got) begin
                check($sformatf("v%0d_no_outcome", idx), 32'h0, 32'h1);
            end else begin
                check($sformatf("v%0d_flags", idx), {27'h0, flags_act()}, {27'h0, e_fl});
                check($sformatf("v%0d_cyc_drop", idx), {31'h0, dwbm_cyc_o}, 32'h0);
                check($sformatf("v%0d_busy_done", idx), {31'h0, lsu_busy_o}, 32'h0);
                if (e_fl[4] && !v.wr) model_rdata = e_res;
                check($sformatf("v%0d_rdata", idx), lsu_rdata_o, model_rdata);
                if (e_fl[1] || e_fl[0]) check($sformatf("v%0d_mtval", idx), lsu_mtval_o, e_res);
                e_busy = (v.resp == R_NONE) ? 32'(1 + TMO) : 32'(1 + dly);
                check($sformatf("v%0d_busy_cycles", idx), 32'(busy_cnt), e_busy);
                @(posedge clk_i); #1;
                check($sformatf("v%0d_one_cycle", idx), {27'h0, flags_act()}, 32'h0);
            end
        end
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF00, R_ACK, 2, 3'b000, 1'b0, 5'b10000, 32'hFFFFFF80, 4'h0, 32'h0};
        vt[1]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, R_ACK, 1, 3'b000, 1'b0, 5'b10000, 32'h0, 4'b1100, 32'hABCDABCD};
        vt[2]  = '{1'b1, 1'b0, 3'b010, 32'h106, 32'h0, 32'h0, R_NONE, 0, 3'b000, 1'b1, 5'b01000, 32'h106, 4'h0, 32'h0};
        vt[3]  = '{1'b0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, R_ERR, 1, 3'b000, 1'b0, 5'b00001, 32'h40, 4'b1111, 32'hDEADBEEF};
        vt[4]  = '{1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, R_NONE, 0, 3'b000, 1'b0, 5'b00010, 32'h200, 4'h0, 32'h0};
        vt[5]  = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h00008056, R_ACK, 0, 3'b000, 1'b0, 5'b10000, 32'h00000080, 4'h0, 32'h0};
        vt[6]  = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80017FFF, R_ACK, 0, 3'b000, 1'b0, 5'b10000, 32'hFFFF8001, 4'h0, 32'h0};
        vt[7]  = '{1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 32'h8001F00D, R_ACK, 0, 3'b000, 1'b0, 5'b10000, 32'h0000F00D, 4'h0, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 3'b000, 32'h3, 32'h000000A5, 32'h0, R_ACK, 0, 3'b000, 1'b0, 5'b10000, 32'h0, 4'b1000, 32'hA5A5A5A5};
        vt[9]  = '{1'b0, 1'b1, 3'b001, 32'h1, 32'h0, 32'h0, R_NONE, 0, 3'b000, 1'b1, 5'b00100, 32'h1, 4'h0, 32'h0};
        vt[10] = '{1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, R_NONE, 0, 3'b000, 1'b1, 5'b00010, 32'h10, 4'h0, 32'h0};
        vt[11] = '{1'b0, 1'b1, 3'b110, 32'h20, 32'h0, 32'h0, R_NONE, 0, 3'b000, 1'b1, 5'b00001, 32'h20, 4'h0, 32'h0};
        vt[12] = '{1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, R_NONE, 0, 3'b100, 1'b1, 5'b00000, 32'h0, 4'h0, 32'h0};
        vt[13] = '{1'b1, 1'b1, 3'b010, 32'h44, 32'h11223344, 32'h0, R_ACK, 0, 3'b000, 1'b0, 5'b10000, 32'h0, 4'b1111, 32'h11223344};
        vt[14] = '{1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, R_BOTH, 2, 3'b000, 1'b0, 5'b10000, 32'hCAFEF00D, 4'h0, 32'h0};
        vt[15] = '{1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, R_NONE, 0, 3'b000, 1'b1, 5'b01000, 32'h103, 4'h0, 32'h0};
        vt[16] = '{1'b0, 1'b1, 3'b010, 32'h8, 32'h0, 32'h0, R_NONE, 0, 3'b010, 1'b1, 5'b00000, 32'h0, 4'h0, 32'h0};
        vt[17] = '{1'b0, 1'b1, 3'b010, 32'h8, 32'h0, 32'h0, R_NONE, 0, 3'b001, 1'b1, 5'b00000, 32'h0, 4'h0, 32'h0};
        vt[18] = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h00C30000, R_ACK, 0, 3'b000, 1'b0, 5'b10000, 32'hFFFFFFC3, 4'h0, 32'h0};
        vt[19] = '{1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'h1234567F, R_ACK, 0, 3'b000, 1'b0, 5'b10000, 32'h0000007F, 4'h0, 32'h0};

        // Reset
        rst_ni = 1'b0;
        idle_inputs();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        dwbm_dat_i = 32'h0;
        dwbm_ack_i = 1'b0;
        dwbm_err_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_cyc", {29'h0, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o}, 32'h0);
        check("rst_flags", {26'h0, lsu_busy_o, flags_act()}, 32'h0);
        check("rst_rdata", lsu_rdata_o, 32'h0);
        check("rst_mtval", lsu_mtval_o, 32'h0);
        check("rst_addr_sel", {28'h0, dwbm_sel_o} | dwbm_addr_o, 32'h0);
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vt[i], i);
        end

        // Kill while a faulting store is in flight: bus finishes, no report.
        @(negedge clk_i);
        drive(1'b0, 1'b1, 3'b010, 32'h80, 32'h55AA55AA);
        exp_q.push_back(32'h0);
        flag_q.push_back(5'b00000);
        @(posedge clk_i); #1;
        idle_inputs();
        check("kill_cyc", {31'h0, dwbm_cyc_o}, 32'h1);
        wb_kill_i  = 1'b1;
        dwbm_err_i = 1'b1;
        @(posedge clk_i); #1;
        wb_kill_i  = 1'b0;
        dwbm_err_i = 1'b0;
        check("kill_cyc_drop", {31'h0, dwbm_cyc_o}, 32'h0);
        check("kill_flags", {27'h0, flags_act()}, {27'h0, flag_q.pop_front()});
        void'(exp_q.pop_front());
        @(posedge clk_i); #1;
        check("kill_after", {26'h0, lsu_busy_o, flags_act()}, 32'h0);

        // Reset asserted in the middle of a bus cycle.
        @(negedge clk_i);
        drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        @(posedge clk_i); #1;
        idle_inputs();
        check("rmid_cyc", {31'h0, dwbm_cyc_o}, 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rmid_cyc_drop", {29'h0, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o}, 32'h0);
        check("rmid_busy", {31'h0, lsu_busy_o}, 32'h0);
        check("rmid_addr", dwbm_addr_o, 32'h0);
        check("rmid_rdata", lsu_rdata_o, 32'h0);
        model_rdata = 32'h0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rmid_no_start", {30'h0, dwbm_cyc_o, lsu_busy_o}, 32'h0);
        run_vec(vt[6], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so a stuck run still reports.
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
